// File: rtl/cr_tx_scheduler_pkg.sv
// Shared types and width helpers for the congestion-recovery transmit scheduler.
package cr_tx_scheduler_pkg;

    // Retransmit queue index width; the pending count needs one extra bit to hold a full queue.
    localparam int PKT_QUEUE_IND_W = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } tx_state_e;

    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 32'sd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cr_rr_arbiter.sv
// Combinational round-robin pick: first eligible flow at or after the pointer, wrapping.
module cr_rr_arbiter
    import cr_tx_scheduler_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = clogb2(NUM_FLOWS)
)(
    input  logic [NUM_FLOWS-1:0] i_eligible,
    input  logic [FLOW_ID_W-1:0] i_rr_ptr,
    output logic                 o_found,
    output logic [FLOW_ID_W-1:0] o_winner
);

    logic [2*NUM_FLOWS-1:0] w_masked;
    logic [FLOW_ID_W:0]     w_idx;

    // Lower copy is masked below the pointer, upper copy is whole, so the lowest set bit wraps.
    always_comb begin
        w_masked = {i_eligible, i_eligible} & ({(2*NUM_FLOWS){1'b1}} << i_rr_ptr);
        w_idx    = '0;
        for (int i = 2*NUM_FLOWS-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_idx = (FLOW_ID_W+1)'(i);
            end else begin
                w_idx = w_idx;
            end
        end
        o_found  = |i_eligible;
        o_winner = w_idx[FLOW_ID_W-1:0];
    end

endmodule

// File: rtl/cr_tx_scheduler.sv
// Round-robin scheduler for CR retransmit pops with per-flow pending counts and in-flight locks.
module cr_tx_scheduler
    import cr_tx_scheduler_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_W = clogb2(NUM_FLOWS),
    parameter int CNT_W     = PKT_QUEUE_IND_W + 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enq_valid,
    input  logic [FLOW_ID_W-1:0] enq_flow_id,
    input  logic                 flush_valid,
    input  logic [FLOW_ID_W-1:0] flush_flow_id,
    input  logic [NUM_FLOWS-1:0] pause,
    output logic                 tx_valid,
    output logic [FLOW_ID_W-1:0] tx_flow_id,
    input  logic                 tx_ready,
    input  logic                 done_valid,
    input  logic [FLOW_ID_W-1:0] done_flow_id,
    output logic                 err_overflow,
    output logic                 err_spurious_done
);

    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FLOW_ID_W-1:0] ID_ONE  = {{(FLOW_ID_W-1){1'b0}}, 1'b1};

    tx_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt     [NUM_FLOWS];
    logic [CNT_W-1:0]     w_cnt_nxt [NUM_FLOWS];
    logic [NUM_FLOWS-1:0] r_inflight, w_inflight_nxt, w_eligible, w_dec;
    logic [FLOW_ID_W-1:0] r_rr_ptr, r_tx_flow_id, w_winner;
    logic                 r_err_overflow, r_err_spurious;
    logic                 w_found, w_load, w_issue, w_ovf, w_spur;

    // Eligibility uses registered counts and locks; a flow cleared by done waits one cycle.
    always_comb begin
        w_eligible = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            w_eligible[f] = (r_cnt[f] != '0) && !r_inflight[f] && !pause[f];
        end
    end

    cr_rr_arbiter #(
        .NUM_FLOWS (NUM_FLOWS),
        .FLOW_ID_W (FLOW_ID_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_found    (w_found),
        .o_winner   (w_winner)
    );

    // Output FSM: reload when empty or when the held event is accepted.
    always_comb begin
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: w_load = 1'b1;
            ST_HOLD:  w_load = tx_ready;
            default:  w_load = 1'b1;
        endcase
        w_issue = w_load && w_found;
        if (w_load) begin
            w_state_nxt = w_found ? ST_HOLD : ST_EMPTY;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Per-flow count and lock updates; flush beats enq, and enq plus issue of one flow nets to zero.
    always_comb begin
        w_dec          = '0;
        w_ovf          = 1'b0;
        w_spur         = 1'b0;
        w_inflight_nxt = r_inflight;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            w_dec[f]     = w_issue && (w_winner == FLOW_ID_W'(f));
            w_cnt_nxt[f] = r_cnt[f];
            if (flush_valid && (flush_flow_id == FLOW_ID_W'(f))) begin
                w_cnt_nxt[f] = '0;
            end else if (enq_valid && (enq_flow_id == FLOW_ID_W'(f)) && !w_dec[f]) begin
                if (r_cnt[f] == CNT_MAX) begin
                    w_ovf = 1'b1;
                end else begin
                    w_cnt_nxt[f] = r_cnt[f] + CNT_ONE;
                end
            end else if (w_dec[f] && !(enq_valid && (enq_flow_id == FLOW_ID_W'(f)))) begin
                w_cnt_nxt[f] = r_cnt[f] - CNT_ONE;
            end else begin
                w_cnt_nxt[f] = r_cnt[f];
            end
            if (done_valid && (done_flow_id == FLOW_ID_W'(f))) begin
                if (r_inflight[f]) begin
                    w_inflight_nxt[f] = 1'b0;
                end else begin
                    w_spur = 1'b1;
                end
            end else begin
                w_inflight_nxt[f] = w_inflight_nxt[f];
            end
            if (w_dec[f]) begin
                w_inflight_nxt[f] = 1'b1;
            end else begin
                w_inflight_nxt[f] = w_inflight_nxt[f];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, locks, round-robin pointer, held flow id and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                r_cnt[f] <= '0;
            end
            r_inflight     <= '0;
            r_rr_ptr       <= '0;
            r_tx_flow_id   <= '0;
            r_err_overflow <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                r_cnt[f] <= w_cnt_nxt[f];
            end
            r_inflight <= w_inflight_nxt;
            if (w_issue) begin
                r_rr_ptr     <= w_winner + ID_ONE;
                r_tx_flow_id <= w_winner;
            end
            if (w_ovf) begin
                r_err_overflow <= 1'b1;
            end
            if (w_spur) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign tx_valid          = (r_state == ST_HOLD);
    assign tx_flow_id        = r_tx_flow_id;
    assign err_overflow      = r_err_overflow;
    assign err_spurious_done = r_err_spurious;

endmodule
